// File: rtl/cp0_unit_if.sv
// Pipeline-side bus of the CP0 controller: mfc0/mtc0 access, victim info from M,
// hardware interrupt lines, and the flush request / EPC returned to the pipeline.
interface cp0_unit_if;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exccode_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic [31:0] epc_out;
    logic        req;

    modport master (
        output en, cp0_addr, cp0_in, vpc, bd_in, exccode_in, hw_int, exl_clr,
        input  cp0_out, epc_out, req
    );

    modport slave (
        input  en, cp0_addr, cp0_in, vpc, bd_in, exccode_in, hw_int, exl_clr,
        output cp0_out, epc_out, req
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt controller: SR, Cause, EPC and PRId registers,
// flush request generation and EPC capture for the M stage.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h4D49_5053
) (
    input  logic        clk,
    input  logic        reset,
    cp0_unit_if.slave   bus
);

    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [5:0]  ip_r;
    logic [4:0]  exccode_r;
    logic [31:0] epc_r;

    logic        int_req_s;
    logic        exc_req_s;
    logic        req_s;
    logic [31:0] vpc_aligned_s;
    logic [31:0] epc_victim_s;
    logic [31:0] sr_s;
    logic [31:0] cause_s;
    logic [31:0] cp0_out_s;

    assign int_req_s     = ie_r & ~exl_r & (|(bus.hw_int & im_r));
    assign exc_req_s     = ~exl_r & (bus.exccode_in != 5'd0);
    assign req_s         = int_req_s | exc_req_s;
    // A delay-slot victim restarts at its branch so the branch is re-executed.
    assign vpc_aligned_s = {bus.vpc[31:2], 2'b00};
    assign epc_victim_s  = bus.bd_in ? (vpc_aligned_s - 32'd4) : vpc_aligned_s;

    assign sr_s    = {16'd0, im_r, 8'd0, exl_r, ie_r};
    assign cause_s = {bd_r, 15'd0, ip_r, 3'd0, exccode_r, 2'b00};

    // CP0 state: exception capture has priority over mtc0, eret clears EXL last.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_r      <= 6'd0;
            exl_r     <= 1'b0;
            ie_r      <= 1'b0;
            bd_r      <= 1'b0;
            ip_r      <= 6'd0;
            exccode_r <= 5'd0;
            epc_r     <= 32'd0;
        end else begin
            ip_r <= bus.hw_int;
            if (req_s) begin
                exl_r     <= 1'b1;
                exccode_r <= int_req_s ? 5'd0 : bus.exccode_in;
                bd_r      <= bus.bd_in;
                epc_r     <= epc_victim_s;
            end else begin
                if (bus.en && (bus.cp0_addr == 5'd12)) begin
                    im_r  <= bus.cp0_in[15:10];
                    ie_r  <= bus.cp0_in[0];
                    exl_r <= bus.cp0_in[1] & ~bus.exl_clr;
                end else if (bus.exl_clr) begin
                    exl_r <= 1'b0;
                end else begin
                    exl_r <= exl_r;
                end
                if (bus.en && (bus.cp0_addr == 5'd14)) begin
                    epc_r <= {bus.cp0_in[31:2], 2'b00};
                end else begin
                    epc_r <= epc_r;
                end
            end
        end
    end

    // mfc0 read mux; unmapped registers read as zero.
    always_comb begin
        cp0_out_s = 32'd0;
        case (bus.cp0_addr)
            5'd12:   cp0_out_s = sr_s;
            5'd13:   cp0_out_s = cause_s;
            5'd14:   cp0_out_s = epc_r;
            5'd15:   cp0_out_s = PRID_VALUE;
            default: cp0_out_s = 32'd0;
        endcase
    end

    assign bus.cp0_out = cp0_out_s;
    assign bus.epc_out = epc_r;
    assign bus.req     = req_s;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: expected values are queued as stimulus is driven
// and popped against the DUT outputs sampled 1 ns after each falling edge.
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h4D49_5053;

    logic clk;
    logic reset;
    cp0_unit_if bus ();

    cp0_unit #(.PRID_VALUE(PRID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_compared;
    int n_mismatched;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] act);
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            check_value("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_value(e.tag, act, e.exp);
        end
    endtask

    // One cycle of arbitrary stimulus, checking req before the commit edge.
    task automatic ev(input string tag, input logic en, input logic [4:0] addr,
                      input logic [31:0] din, input logic [31:0] pc, input logic bd,
                      input logic [4:0] exc, input logic [5:0] hw, input logic clr,
                      input logic exp_req);
        @(negedge clk);
        bus.en         = en;
        bus.cp0_addr   = addr;
        bus.cp0_in     = din;
        bus.vpc        = pc;
        bus.bd_in      = bd;
        bus.exccode_in = exc;
        bus.hw_int     = hw;
        bus.exl_clr    = clr;
        sb_push(tag, {31'd0, exp_req});
        #1;
        sb_pop_check({31'd0, bus.req});
    endtask

    // One quiet cycle reading a CP0 register; hw_int is left as it was.
    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        @(negedge clk);
        bus.en         = 1'b0;
        bus.cp0_addr   = addr;
        bus.cp0_in     = 32'd0;
        bus.bd_in      = 1'b0;
        bus.exccode_in = 5'd0;
        bus.exl_clr    = 1'b0;
        sb_push(tag, exp);
        #1;
        sb_pop_check(bus.cp0_out);
    endtask

    task automatic epc_chk(input string tag, input logic [31:0] exp);
        @(negedge clk);
        bus.en         = 1'b0;
        bus.exccode_in = 5'd0;
        bus.exl_clr    = 1'b0;
        sb_push(tag, exp);
        #1;
        sb_pop_check(bus.epc_out);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_compared     = 0;
        n_mismatched   = 0;
        reset          = 1'b1;
        bus.en         = 1'b0;
        bus.cp0_addr   = 5'd0;
        bus.cp0_in     = 32'd0;
        bus.vpc        = 32'd0;
        bus.bd_in      = 1'b0;
        bus.exccode_in = 5'd0;
        bus.hw_int     = 6'd0;
        bus.exl_clr    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        rd("sr_rst", 5'd12, 32'd0);
        rd("cause_rst", 5'd13, 32'd0);
        rd("epc_rst", 5'd14, 32'd0);
        rd("prid", 5'd15, PRID);
        rd("unmapped", 5'd5, 32'd0);
        epc_chk("epc_out_rst", 32'd0);
        ev("req_rst_hwint", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 6'h3F, 1'b0, 1'b0);

        // plain exception
        ev("req_adel", 1'b0, 5'd0, 32'd0, 32'h3010, 1'b0, 5'd4, 6'd0, 1'b0, 1'b1);
        rd("epc_adel", 5'd14, 32'h3010);
        epc_chk("epc_out_adel", 32'h3010);
        rd("cause_adel", 5'd13, 32'h0000_0010);
        rd("sr_exl", 5'd12, 32'h0000_0002);
        ev("req_nested", 1'b0, 5'd0, 32'd0, 32'h3050, 1'b0, 5'd10, 6'd0, 1'b0, 1'b0);
        rd("epc_held", 5'd14, 32'h3010);
        rd("cause_held", 5'd13, 32'h0000_0010);

        // delay-slot exception and eret
        ev("eret1", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0);
        rd("sr_eret1", 5'd12, 32'd0);
        ev("req_bd", 1'b0, 5'd0, 32'd0, 32'h3024, 1'b1, 5'd12, 6'd0, 1'b0, 1'b1);
        rd("epc_bd", 5'd14, 32'h3020);
        rd("cause_bd", 5'd13, 32'h8000_0030);
        ev("eret2", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0);
        rd("sr_eret2", 5'd12, 32'd0);
        ev("req_refire", 1'b0, 5'd0, 32'd0, 32'h3100, 1'b0, 5'd4, 6'd0, 1'b1, 1'b1);
        rd("sr_clr_loses", 5'd12, 32'h0000_0002);
        rd("epc_refire", 5'd14, 32'h3100);

        // interrupt versus exception
        ev("mtc0_sr", 1'b1, 5'd12, 32'h0000_0401, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        rd("sr_written", 5'd12, 32'h0000_0401);
        ev("req_int", 1'b0, 5'd0, 32'd0, 32'h3040, 1'b0, 5'd8, 6'd1, 1'b0, 1'b1);
        rd("cause_int", 5'd13, 32'h0000_0400);
        rd("sr_int", 5'd12, 32'h0000_0403);
        rd("epc_int", 5'd14, 32'h3040);
        ev("mtc0_sr_noie", 1'b1, 5'd12, 32'h0000_0400, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        rd("sr_noie", 5'd12, 32'h0000_0400);
        ev("req_int_ie0", 1'b0, 5'd0, 32'd0, 32'h3060, 1'b0, 5'd0, 6'd1, 1'b0, 1'b0);

        // mtc0 colliding with an exception, then an unaligned EPC write
        ev("req_collide", 1'b1, 5'd14, 32'h5000, 32'h3008, 1'b0, 5'd4, 6'd0, 1'b0, 1'b1);
        rd("epc_collide", 5'd14, 32'h3008);
        ev("mtc0_epc", 1'b1, 5'd14, 32'h3003, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        sb_push("epc_raw_old", 32'h3008);
        sb_pop_check(bus.cp0_out);
        epc_chk("epc_out_mtc0", 32'h3000);
        ev("mtc0_sr_clr", 1'b1, 5'd12, 32'h0000_0403, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0);
        rd("sr_mtc0_clr", 5'd12, 32'h0000_0401);

        // EPC wrap and ignored writes
        ev("req_wrap", 1'b0, 5'd0, 32'd0, 32'h0000_0000, 1'b1, 5'd4, 6'd0, 1'b0, 1'b1);
        rd("epc_wrap", 5'd14, 32'hFFFF_FFFC);
        rd("cause_wrap", 5'd13, 32'h8000_0010);
        ev("mtc0_cause", 1'b1, 5'd13, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        rd("cause_ro", 5'd13, 32'h8000_0010);
        ev("mtc0_prid", 1'b1, 5'd15, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        rd("prid_ro", 5'd15, PRID);

        // reset in the middle of operation
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd("sr_rst2", 5'd12, 32'd0);
        rd("cause_rst2", 5'd13, 32'd0);
        rd("epc_rst2", 5'd14, 32'd0);
        epc_chk("epc_out_rst2", 32'd0);
        ev("req_rst2", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 6'h3F, 1'b0, 1'b0);

        if (sb_q.size() != 0) begin
            check_value("sb_leftover", sb_q.size(), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS microsystem; sits beside the M stage.
- Consumes the exception code, branch-delay flag and victim PC carried down the pipeline registers, plus the external hardware interrupt lines.
- Produces the pipeline-wide flush request (Req) and the return address (EPC) used by eret.
- Implements the SR, Cause, EPC and PRId registers, accessed by mfc0/mtc0.

Parameters:
PRID_VALUE, 32'h4D49_5053, constant returned on reads of PRId (reg 15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
en  in  1  mtc0 write enable (M stage)
cp0_addr  in  5  CP0 register number for read/write
cp0_in  in  32  mtc0 write data
cp0_out  out  32  mfc0 read data (combinational)
vpc  in  32  PC of the instruction currently in M (victim PC)
bd_in  in  1  victim instruction sits in a branch delay slot
exccode_in  in  5  pipelined exception code of victim; 0 = no exception
hw_int  in  6  external interrupt lines, level-sensitive
exl_clr  in  1  eret in M: clear EXL
epc_out  out  32  current EPC register value
req  out  1  exception/interrupt taken this cycle; flushes all pipeline registers and redirects fetch to 0x4180

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): PRID_VALUE.
- Reset: SR=0, Cause=0, EPC=0, so req=0, epc_out=0, cp0_out=0 unless addr=15.
- Interrupt pending: int_req = IE & ~EXL & |(hw_int & IM).
- Exception pending: exc_req = ~EXL & (exccode_in != 0).
- Request: req = int_req | exc_req. Combinational, same cycle, so the flush happens on the next clk edge together with the CP0 update.
- Priority: an interrupt beats a synchronous exception. When both are pending, ExcCode is recorded as 0 (Int).
- On a clk edge with req=1:
  - EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : exccode_in.
  - Cause.BD <= bd_in.
  - EPC <= bd_in ? {vpc[31:2],2'b00} - 4 : {vpc[31:2],2'b00}. The subtraction is 32-bit and wraps modulo 2^32.
- Cause.IP <= hw_int every cycle, unconditionally and independent of req/EXL. It reflects the lines with one-cycle latency.
- mtc0 (en=1, req=0):
  - addr 12 writes IM, EXL, IE from cp0_in.
  - addr 14 writes EPC with {cp0_in[31:2],2'b00}.
  - Writes to 13, 15 or any other address are ignored.
- Collision rules:
  - req=1 and en=1 in the same cycle: the write is discarded and the exception update wins.
  - exl_clr=1 and en=1 writing SR in the same cycle: the mtc0 value is written, then EXL is forced to 0.
  - exl_clr=1 and req=1 in the same cycle: the exception wins and EXL stays 1.
  - exl_clr with EXL already 0 has no effect.
- Nested events: while EXL=1, req is held at 0 regardless of hw_int or exccode_in. No nesting; EPC, Cause.BD and ExcCode are held.
- Reads: cp0_out is a combinational mux on cp0_addr: 12→SR, 13→Cause, 14→EPC, 15→PRId, else 0. Read-after-write in the same cycle returns the old value.
- epc_out is a direct register output. A mtc0 to EPC is visible on epc_out the cycle after the write.
- Reset mid-operation: all registers return to their reset values on the next edge; req deasserts combinationally once EXL/IE/IM are cleared. A pending exccode_in during reset is lost.

Test Plan:
- Reset, then read addr 12/13/14/15 → 0, 0, 0, PRID_VALUE; req=0 with hw_int=6'h3F and exccode_in=0.
- Exception, not in delay slot: exccode_in=4 (AdEL), bd_in=0, vpc=0x3010 → req=1 that cycle; next cycle EPC=0x3010, Cause.ExcCode=4, BD=0, EXL=1; a second exccode_in=10 then gives req=0.
- Delay-slot exception: exccode_in=12, bd_in=1, vpc=0x3024 → EPC=0x3020, Cause[31]=1, ExcCode=12. Then pulse exl_clr → EXL=0 next cycle and req can fire again.
- Interrupt vs exception: mtc0 SR=0x0000_0401 (IM[10], IE), then hw_int=6'b000001 with exccode_in=8 in the same cycle → req=1 and Cause.ExcCode=0; Cause.IP[10]=1 one cycle after hw_int rises. Repeat with IE=0 → req=0.
- Collision: en=1, addr=14, cp0_in=0x5000 in the same cycle as exccode_in=4, vpc=0x3008 → EPC=0x3008 (write dropped). Separately, write addr 14 with 0x3003 → EPC=0x3000.
- Wrap and ignored writes: bd_in=1, vpc=0x0000_0000 → EPC=0xFFFF_FFFC. A mtc0 to addr 13 with 0xFFFF_FFFF leaves Cause unchanged.
